// File: rtl/key_press_pulser.sv
// Debounced push-button front end: per key a two-flop synchronizer, a debounce
// counter and a four-state FSM that emit a level plus one-cycle press/release strobes.
module key_press_pulser #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] pressed,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      UP           = 2'd0,
      PRESS_WAIT   = 2'd1,
      DOWN         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   genvar g;
   for (g = 0; g < NUM_KEYS; g++) begin : g_key
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             sync_lvl;
      key_state_e       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             pressed_q, pressed_d;
      logic             press_pulse_q, press_pulse_d;
      logic             release_pulse_q, release_pulse_d;

      assign sync_lvl = ~sync2_q;

      always_comb begin
         sync1_d         = key_n[g];
         sync2_d         = sync1_q;
         state_d         = state_q;
         cnt_d           = cnt_q;
         // Strobes fire on the first registered cycle of the new debounced level;
         // RELEASE_WAIT still counts as pressed, so a rejected release glitch never re-strobes.
         pressed_d       = (state_q == DOWN) || (state_q == RELEASE_WAIT);
         press_pulse_d   = (state_q == DOWN) && !pressed_q;
         release_pulse_d = (state_q == UP) && pressed_q;
         case (state_q)
            UP: begin
               if (sync_lvl) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync_lvl) begin
                  state_d = UP;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = DOWN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            DOWN: begin
               if (!sync_lvl) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (sync_lvl) begin
                  state_d = DOWN;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = UP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = UP;
               cnt_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= UP;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
         end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
         end
      end

      assign pressed[g]       = pressed_q;
      assign press_pulse[g]   = press_pulse_q;
      assign release_pulse[g] = release_pulse_q;
   end

endmodule

// File: tb/tb_key_press_pulser.sv
// Directed bench for key_press_pulser with DEBOUNCE_CYCLES=4, NUM_KEYS=4.
// Inputs change 1 ns after a rising edge; outputs are read 1 ns after the next one.
module tb_key_press_pulser;

   localparam int NK = 4;

   logic          clk;
   logic          reset;
   logic [NK-1:0] key_n;
   logic [NK-1:0] pressed;
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;

   int n_tests;
   int n_fail;

   key_press_pulser #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      key_n = '1;
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset();
      logic [3*NK-1:0] exp;
      exp = '0;
      reset = 1'b0;
      key_n = 4'b0000;
      for (int t = 1; t <= 5; t++) begin
         tick();
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL reset_hold t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      key_n = '1;
      tick();
      reset = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL reset_idle t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
   endtask

   task automatic test_clean_press();
      logic [3*NK-1:0] exp;
      key_n = 4'b1101;
      for (int t = 1; t <= 20; t++) begin
         tick();
         exp = {(t >= 7) ? 4'b0010 : 4'b0000, (t == 7) ? 4'b0010 : 4'b0000, 4'b0000};
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL clean_press t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
   endtask

   task automatic test_release();
      logic [3*NK-1:0] exp;
      key_n = 4'b1111;
      for (int t = 1; t <= 12; t++) begin
         tick();
         exp = {(t < 7) ? 4'b0010 : 4'b0000, 4'b0000, (t == 7) ? 4'b0010 : 4'b0000};
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL release t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      key_n = 4'b1101;
      for (int i = 0; i < 10; i++) tick();
      exp = {4'b0010, 4'b0000, 4'b0000};
      for (int t = 1; t <= 15; t++) begin
         key_n = (t <= 2) ? 4'b1111 : 4'b1101;
         tick();
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL release_glitch t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      drain();
   endtask

   task automatic test_bounce();
      logic [3*NK-1:0] exp;
      for (int t = 1; t <= 16; t++) begin
         key_n = (t == 4) ? 4'b1111 : 4'b1011;
         tick();
         exp = {(t >= 11) ? 4'b0100 : 4'b0000, (t == 11) ? 4'b0100 : 4'b0000, 4'b0000};
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL bounce t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      drain();
   endtask

   task automatic test_simultaneous();
      logic [3*NK-1:0] exp;
      key_n = 4'b0101;
      for (int t = 1; t <= 10; t++) begin
         tick();
         exp = {(t >= 7) ? 4'b1010 : 4'b0000, (t == 7) ? 4'b1010 : 4'b0000, 4'b0000};
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL simul_a t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      key_n = 4'b0000;
      for (int t = 1; t <= 10; t++) begin
         tick();
         exp = {(t >= 7) ? 4'b1111 : 4'b1010, (t == 7) ? 4'b0101 : 4'b0000, 4'b0000};
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL simul_b t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      drain();
      n_tests++;
      if (pressed !== 4'b0000) begin
         $display("FAIL simul_drain actual=%b required=%b", pressed, 4'b0000);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      logic [3*NK-1:0] exp;
      logic            p;
      key_n = 4'b1110;
      for (int t = 1; t <= 26; t++) begin
         reset = ((t >= 5 && t <= 7) || (t >= 16 && t <= 17)) ? 1'b0 : 1'b1;
         tick();
         p   = (t >= 14 && t <= 15) || (t >= 24);
         exp = {{3'b000, p}, (t == 14 || t == 24) ? 4'b0001 : 4'b0000, 4'b0000};
         n_tests++;
         if ({pressed, press_pulse, release_pulse} !== exp) begin
            $display("FAIL reset_mid t=%0d actual=%b required=%b", t, {pressed, press_pulse, release_pulse}, exp);
            n_fail++;
         end
      end
      reset = 1'b1;
      drain();
   endtask

   task automatic test_hold();
      int pc, first_t, bad, rc, rel_t, both;
      pc = 0; first_t = -1; bad = 0; rc = 0; rel_t = -1; both = 0;
      key_n = 4'b0111;
      for (int t = 1; t <= 1000; t++) begin
         tick();
         if (press_pulse[3]) begin
            pc++;
            if (first_t < 0) first_t = t;
         end
         if (t >= 7 && !pressed[3]) bad++;
         if (release_pulse !== 4'b0000 || press_pulse[2:0] !== 3'b000 || pressed[2:0] !== 3'b000) bad++;
      end
      n_tests++;
      if (pc != 1) begin
         $display("FAIL hold_pulse_count actual=%0d required=%0d", pc, 1);
         n_fail++;
      end
      n_tests++;
      if (first_t != 7) begin
         $display("FAIL hold_pulse_tick actual=%0d required=%0d", first_t, 7);
         n_fail++;
      end
      n_tests++;
      if (bad != 0) begin
         $display("FAIL hold_level actual=%0d required=%0d", bad, 0);
         n_fail++;
      end
      key_n = 4'b1111;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (release_pulse[3]) begin
            rc++;
            if (rel_t < 0) rel_t = t;
         end
         if ((press_pulse & release_pulse) !== 4'b0000 || press_pulse !== 4'b0000) both++;
      end
      n_tests++;
      if (rc != 1 || rel_t != 7) begin
         $display("FAIL hold_release actual=%0d@%0d required=1@7", rc, rel_t);
         n_fail++;
      end
      n_tests++;
      if (both != 0 || pressed !== 4'b0000) begin
         $display("FAIL hold_release_clean actual=%0d/%b required=0/0000", both, pressed);
         n_fail++;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      key_n   = '1;
      test_reset();
      test_clean_press();
      test_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_press_pulser.md
KEY_PRESS_PULSER -- requirements
Module: key_press_pulser

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles (5 ms at 50 MHz) required to accept a level change; legal range 2..2^20.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-005 SHALL have port key_n  input  NUM_KEYS  raw asynchronous push-button levels; 0 = pressed.
REQ-006 SHALL have port pressed  output  NUM_KEYS  debounced key level; 1 = pressed.
REQ-007 SHALL have port press_pulse  output  NUM_KEYS  one-cycle strobe per accepted press; drives FIFO read/write requests.
REQ-008 SHALL have port release_pulse  output  NUM_KEYS  one-cycle strobe per accepted release.

Function
REQ-009 SHALL pass each key_n bit through a two-flop synchronizer before any other logic; sync output is inverted to active-high (sync_lvl).
REQ-010 SHALL implement one independent channel per key: synchronizer, debounce counter of ceil(log2(DEBOUNCE_CYCLES)) bits, per-key FSM.
REQ-011 SHALL use FSM states UP, PRESS_WAIT, DOWN, RELEASE_WAIT.
REQ-012 UP: sync_lvl=1 -> PRESS_WAIT, counter=1; else stay, counter=0.
REQ-013 PRESS_WAIT: sync_lvl=0 -> UP, counter=0 (glitch rejected, no pulse); sync_lvl=1 and counter=DEBOUNCE_CYCLES-1 -> DOWN, counter=0; else counter+1.
REQ-014 DOWN: sync_lvl=0 -> RELEASE_WAIT, counter=1; else stay.
REQ-015 RELEASE_WAIT: sync_lvl=1 -> DOWN, counter=0 (no pulse); sync_lvl=0 and counter=DEBOUNCE_CYCLES-1 -> UP, counter=0; else counter+1.
REQ-016 pressed SHALL be registered, 1 exactly in states DOWN and RELEASE_WAIT.
REQ-017 press_pulse SHALL be high for exactly one cycle, the cycle the FSM first enters DOWN from PRESS_WAIT; never on RELEASE_WAIT -> DOWN.
REQ-018 release_pulse SHALL be high for exactly one cycle, the cycle the FSM first enters UP from RELEASE_WAIT.
REQ-019 Latency: a clean press sampled low at edge k SHALL produce press_pulse high in cycle following edge k+DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES debounce); release symmetric.
REQ-020 Holding a key indefinitely SHALL produce exactly one press_pulse (no auto-repeat).
REQ-021 press_pulse and release_pulse for the same key SHALL never be high in the same cycle, and SHALL be separated by at least DEBOUNCE_CYCLES cycles.
REQ-022 Channels SHALL be fully independent; simultaneous presses on several keys SHALL produce pulses in the same cycle on each.
REQ-023 Counter SHALL never wrap; terminal value DEBOUNCE_CYCLES-1 forces a state transition or counter clear.

Reset
REQ-024 reset=0 at a rising edge SHALL force all FSMs to UP, counters and synchronizer flops to the released value, pressed=0, press_pulse=0, release_pulse=0 on the following cycle.
REQ-025 Reset asserted mid-debounce or while DOWN SHALL discard progress with no pulse; a key still held after reset deasserts SHALL be accepted as a fresh press after full latency (REQ-019).
REQ-026 Outputs SHALL remain at reset values while reset=0 regardless of key_n.

Verification (DEBOUNCE_CYCLES=4, NUM_KEYS=4)
REQ-027 Clean press: key_n[1] 1->0 held 20 cycles -> pressed[1]=1 and single press_pulse[1] exactly 6 cycles after first low sample; other bits stay 0.
REQ-028 Bounce: key_n[2] low 3 cycles, high 1, low 10 -> no pulse during bounce; one press_pulse[2] 6 cycles after final low.
REQ-029 Release: after REQ-027, key_n[1] 0->1 -> release_pulse[1] once 6 cycles later, pressed[1]=0; 2-cycle release glitch -> no release_pulse.
REQ-030 Simultaneous: key_n=4'b0101 -> 4'b0000 same edge -> press_pulse=4'b1010 then (after further 0101 low) correct per-key timing, no cross-talk.
REQ-031 Reset mid-operation: key_n[0] low, reset=0 at debounce count 2, held 3 cycles, released -> no pulse during reset; press_pulse[0] 6 cycles after reset deasserts.
REQ-032 Hold: key_n[3] low 1000 cycles -> exactly one press_pulse[3], pressed[3]=1 throughout after acceptance.
